// File: rtl/qif_pkg.sv
// Shared types and helpers for the time-multiplexed QIF neuron array.
package qif_pkg;

    // Widest channel index the spike event can carry.
    localparam int unsigned MAX_CH_W = 8;

    // Bits needed to index n items (at least one bit).
    function automatic int unsigned ch_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Spike event as emitted by the write-back stage.
    typedef struct packed {
        logic                valid;
        logic [MAX_CH_W-1:0] ch;
    } spike_evt_t;

    // Clamp a wide signed value into the signed range of w bits.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                    input int unsigned      w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/qif_neuron_array_update.sv
// Combinational stage-2 math: refractory hold, quadratic sum, threshold, clamp.
module qif_update
    import qif_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHIFT   = 4,
    parameter int          V_PEAK  = 96,
    parameter int          V_RESET = -32,
    parameter int unsigned REFRAC  = 2,
    parameter int unsigned RC_W    = 2
) (
    input  logic signed [WIDTH-1:0]   v,
    input  logic signed [WIDTH-1:0]   cur,
    input  logic        [RC_W-1:0]    rc,
    input  logic        [2*WIDTH-1:0] sq,
    output logic signed [WIDTH-1:0]   v_next,
    output logic        [RC_W-1:0]    rc_next,
    output logic                      spike
);

    localparam int unsigned SW = 2 * WIDTH + 2;
    localparam logic signed [SW-1:0] PEAK = SW'(V_PEAK);

    logic signed [SW-1:0] sum;

    assign sum = SW'(v) + $signed({2'b00, sq >> SHIFT}) + SW'(cur);

    // Next potential, refractory count and spike flag for the visited channel.
    always_comb begin
        v_next  = WIDTH'(V_RESET);
        rc_next = '0;
        spike   = 1'b0;
        if (rc != '0) begin
            rc_next = rc - RC_W'(1);
        end else if (sum >= PEAK) begin
            spike   = 1'b1;
            rc_next = RC_W'(REFRAC);
        end else begin
            v_next = WIDTH'(saturate(64'(sum), WIDTH));
        end
    end

endmodule

// File: rtl/qif_neuron_array.sv
// N_CH quadratic integrate-and-fire neurons sharing one two-stage datapath.
module qif_neuron_array
    import qif_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned N_CH    = 4,
    parameter int unsigned SHIFT   = 4,
    parameter int          V_PEAK  = 96,
    parameter int          V_RESET = -32,
    parameter int unsigned REFRAC  = 2,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned CH_W   = ch_w(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    wr_en,
    input  logic        [CH_W-1:0]  wr_ch,
    input  logic signed [WIDTH-1:0] wr_data,
    input  logic        [CH_W-1:0]  mon_ch,
    output logic signed [WIDTH-1:0] v_mon,
    output logic                    spike_valid,
    output logic        [CH_W-1:0]  spike_ch,
    output logic        [CNT_W-1:0] spike_cnt
);

    localparam int unsigned RC_W = ch_w(REFRAC + 1);

    // Per-channel state.
    logic signed [WIDTH-1:0] v_q  [N_CH];
    logic signed [WIDTH-1:0] i_q  [N_CH];
    logic        [RC_W-1:0]  rc_q [N_CH];

    logic [CH_W-1:0] ptr;

    // Stage 1 registers.
    logic                    s1_valid;
    logic [CH_W-1:0]         s1_ch;
    logic signed [WIDTH-1:0] s1_v;
    logic signed [WIDTH-1:0] s1_i;
    logic [RC_W-1:0]         s1_rc;
    logic [2*WIDTH-1:0]      s1_sq;

    spike_evt_t spk_q;

    logic signed [2*WIDTH-1:0] v_ext;
    logic        [2*WIDTH-1:0] sq_now;

    logic signed [WIDTH-1:0] upd_v;
    logic        [RC_W-1:0]  upd_rc;
    logic                    upd_spike;

    // Square of the channel being captured; v*v is never negative.
    always_comb begin
        v_ext  = {{WIDTH{v_q[ptr][WIDTH-1]}}, v_q[ptr]};
        sq_now = v_ext * v_ext;
    end

    qif_update #(
        .WIDTH   (WIDTH),
        .SHIFT   (SHIFT),
        .V_PEAK  (V_PEAK),
        .V_RESET (V_RESET),
        .REFRAC  (REFRAC),
        .RC_W    (RC_W)
    ) u_update (
        .v       (s1_v),
        .cur     (s1_i),
        .rc      (s1_rc),
        .sq      (s1_sq),
        .v_next  (upd_v),
        .rc_next (upd_rc),
        .spike   (upd_spike)
    );

    // Pointer, stage-1 capture, write-back, spike event and counter.
    // The write-back target (s1_ch) always differs from ptr because N_CH >= 2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            s1_valid  <= 1'b0;
            s1_ch     <= '0;
            s1_v      <= '0;
            s1_i      <= '0;
            s1_rc     <= '0;
            s1_sq     <= '0;
            spk_q     <= '0;
            spike_cnt <= '0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                v_q[c]  <= WIDTH'(V_RESET);
                rc_q[c] <= '0;
            end
        end else begin
            spk_q.valid <= 1'b0;
            if (ena) begin
                if (s1_valid) begin
                    v_q[s1_ch]  <= upd_v;
                    rc_q[s1_ch] <= upd_rc;
                    if (upd_spike) begin
                        spk_q.valid <= 1'b1;
                        spk_q.ch    <= MAX_CH_W'(s1_ch);
                        if (spike_cnt != '1)
                            spike_cnt <= spike_cnt + CNT_W'(1);
                    end
                end
                s1_valid <= 1'b1;
                s1_ch    <= ptr;
                s1_v     <= v_q[ptr];
                s1_i     <= i_q[ptr];
                s1_rc    <= rc_q[ptr];
                s1_sq    <= sq_now;
                ptr      <= (ptr == CH_W'(N_CH - 1)) ? '0 : ptr + CH_W'(1);
            end
        end
    end

    // Input-current registers, writable regardless of ena.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < N_CH; c++)
                i_q[c] <= '0;
        end else if (wr_en) begin
            i_q[wr_ch] <= wr_data;
        end
    end

    // Registered monitor copy of the selected channel's potential.
    always_ff @(posedge clk) begin
        if (!rst_n)
            v_mon <= WIDTH'(V_RESET);
        else
            v_mon <= v_q[mon_ch];
    end

    assign spike_valid = spk_q.valid;
    assign spike_ch    = CH_W'(spk_q.ch);

endmodule

// File: tb/tb_qif_neuron_array.sv
// Self-checking bench for qif_neuron_array against a visit-level reference model.
module tb_qif_neuron_array;

    localparam int NCH   = 4;
    localparam int PEAK  = 96;
    localparam int VRST  = -32;
    localparam int RFR   = 2;
    localparam int CMAX  = 65535;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b0;
    logic              wr_en = 1'b0;
    logic        [1:0] wr_ch = '0;
    logic signed [7:0] wr_data = '0;
    logic        [1:0] mon_ch = '0;
    logic signed [7:0] v_mon;
    logic              spike_valid;
    logic        [1:0] spike_ch;
    logic       [15:0] spike_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: committed potentials, currents, refractory counts,
    // plus the single visit that has been captured but not yet written back.
    int mv [NCH];
    int mi [NCH];
    int mrc[NCH];
    int mptr;
    bit p_valid;
    int p_ch, p_v, p_rc;
    bit p_spk;
    int mcnt;
    int since_rst;
    int ch0_spikes[$];

    qif_neuron_array #(
        .WIDTH(8), .N_CH(4), .SHIFT(4), .V_PEAK(96),
        .V_RESET(-32), .REFRAC(2), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_data(wr_data), .mon_ch(mon_ch), .v_mon(v_mon),
        .spike_valid(spike_valid), .spike_ch(spike_ch), .spike_cnt(spike_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            mv[c] = VRST; mi[c] = 0; mrc[c] = 0;
        end
        mptr = 0; p_valid = 0; p_ch = 0; p_v = 0; p_rc = 0; p_spk = 0;
        mcnt = 0; since_rst = -1;
    endtask

    // One neuron visit computed straight from the update rules.
    task automatic model_visit(input int c);
        int sum;
        p_valid = 1; p_ch = c; p_spk = 0;
        if (mrc[c] > 0) begin
            p_v = VRST; p_rc = mrc[c] - 1;
        end else begin
            sum = mv[c] + (mv[c] * mv[c]) / 16 + mi[c];
            if (sum >= PEAK) begin
                p_spk = 1; p_v = VRST; p_rc = RFR;
            end else begin
                p_v = (sum > 127) ? 127 : (sum < -128) ? -128 : sum;
                p_rc = 0;
            end
        end
    endtask

    // Drive one cycle, advance the model across the edge, check outputs 1 time unit later.
    task automatic step(input bit r, input bit e, input bit we, input int wc,
                        input int wd, input int mc);
        bit exp_sv;
        int exp_sch;
        int exp_vm;
        rst_n = !r; ena = e; wr_en = we;
        wr_ch = 2'(wc); wr_data = 8'(wd); mon_ch = 2'(mc);
        @(posedge clk);
        exp_sv = 0; exp_sch = 0;
        if (r) begin
            model_reset();
            exp_vm = VRST;
        end else begin
            since_rst++;
            exp_vm = mv[mc];
            if (e) begin
                if (p_valid) begin
                    mv[p_ch] = p_v; mrc[p_ch] = p_rc;
                    if (p_spk) begin
                        exp_sv = 1; exp_sch = p_ch;
                        if (mcnt < CMAX) mcnt++;
                        if (p_ch == 0) ch0_spikes.push_back(since_rst);
                    end
                end
                model_visit(mptr);
                mptr = (mptr + 1) % NCH;
            end
            if (we) mi[wc] = wd;
        end
        #1;
        total++;
        assert (spike_valid === exp_sv) else begin
            bad++; $error("FAIL spike_valid got=%0b exp=%0b t=%0t", spike_valid, exp_sv, $time);
        end
        if (exp_sv) begin
            total++;
            assert (spike_ch === 2'(exp_sch)) else begin
                bad++; $error("FAIL spike_ch got=%0d exp=%0d t=%0t", spike_ch, exp_sch, $time);
            end
        end
        total++;
        assert (spike_cnt === 16'(mcnt)) else begin
            bad++; $error("FAIL spike_cnt got=%0d exp=%0d t=%0t", spike_cnt, mcnt, $time);
        end
        total++;
        assert (v_mon === 8'(exp_vm)) else begin
            bad++; $error("FAIL v_mon got=%0d exp=%0d t=%0t", v_mon, exp_vm, $time);
        end
    endtask

    initial begin
        model_reset();

        // Reset and hold: every channel reads V_RESET while frozen.
        step(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < NCH; c++) step(0, 0, 0, 0, 0, c);

        // Free run with I=0: channel 0 spikes at edge 5, then every 16 cycles.
        step(1, 0, 0, 0, 0, 0);
        ch0_spikes.delete();
        for (int k = 0; k < 40; k++) step(0, 1, 0, 0, 0, k % NCH);
        total++;
        assert (ch0_spikes.size() >= 2 && ch0_spikes[0] == 5 && ch0_spikes[1] == 21) else begin
            bad++; $error("FAIL ch0_period got_n=%0d exp=5,21", ch0_spikes.size());
        end

        // Stable fixed point at I=-64.
        step(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < NCH; c++) step(0, 0, 1, c, -64, c);
        for (int k = 0; k < 100; k++) step(0, 1, 0, 0, 0, k % NCH);
        total++;
        assert (spike_cnt === 16'd0) else begin
            bad++; $error("FAIL stable_cnt got=%0d exp=0", spike_cnt);
        end

        // Write collision on channel 1 at its capture edge.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 1, 1, -64, 1);
        for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        total++;
        assert (v_mon === 8'sd32) else begin
            bad++; $error("FAIL collision_v got=%0d exp=32", v_mon);
        end

        // Freeze for 10 cycles: channel 0 spikes shift from 21/37 to 31/47.
        step(1, 0, 0, 0, 0, 0);
        ch0_spikes.delete();
        for (int k = 0; k < 8; k++)  step(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0, k % NCH);
        for (int k = 0; k < 40; k++) step(0, 1, 0, 0, 0, k % NCH);
        total++;
        assert (ch0_spikes.size() >= 3 && ch0_spikes[0] == 5 && ch0_spikes[1] == 31
                && ch0_spikes[2] == 47) else begin
            bad++; $error("FAIL freeze_shift got_n=%0d exp=5,31,47", ch0_spikes.size());
        end

        // Reset right after the capture that would spike at edge 5.
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        for (int c = 0; c < NCH; c++) step(0, 0, 0, 0, 0, c);
        total++;
        assert (spike_cnt === 16'd0) else begin
            bad++; $error("FAIL midflight_cnt got=%0d exp=0", spike_cnt);
        end

        // Randomised run: writes, enable gaps, monitor sweeps, rare resets.
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 800; k++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, NCH - 1)),
                 int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, NCH - 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
